// File: rtl/tds_pad_frame_emulator_if.sv
// Pad-side bus of the TDS pad frame emulator: run control, per-link delay selects,
// the four link frame outputs with their strobes, bc0 and the frame counter.
interface tds_pad_frame_emulator_if;
  // pad_data_valid_k is a one-cycle strobe with no ready/backpressure. The consumer
  // must take pad_data_k in that cycle; the data then holds until the next strobe.
  logic         enable;
  logic [11:0]  bcid_preset;
  logic [2:0]   delay_sel_0;
  logic [2:0]   delay_sel_1;
  logic [2:0]   delay_sel_2;
  logic [2:0]   delay_sel_3;
  logic [115:0] pad_data_0;
  logic [115:0] pad_data_1;
  logic [115:0] pad_data_2;
  logic [115:0] pad_data_3;
  logic         pad_data_valid_0;
  logic         pad_data_valid_1;
  logic         pad_data_valid_2;
  logic         pad_data_valid_3;
  logic         bc0;
  logic [31:0]  frame_count;

  modport master (
    output enable, bcid_preset, delay_sel_0, delay_sel_1, delay_sel_2, delay_sel_3,
    input  pad_data_0, pad_data_1, pad_data_2, pad_data_3,
    input  pad_data_valid_0, pad_data_valid_1, pad_data_valid_2, pad_data_valid_3,
    input  bc0, frame_count
  );

  modport slave (
    input  enable, bcid_preset, delay_sel_0, delay_sel_1, delay_sel_2, delay_sel_3,
    output pad_data_0, pad_data_1, pad_data_2, pad_data_3,
    output pad_data_valid_0, pad_data_valid_1, pad_data_valid_2, pad_data_valid_3,
    output bc0, frame_count
  );
endinterface

// File: rtl/tds_pad_frame_emulator.sv
// Emulates four TDS pad links: BCID-stamped frames every FRAME_DIV clocks through a
// per-link frame delay line. Define TDS_EMU_PRBS_EN for a PRBS-31 payload instead of frame_count.
module tds_pad_frame_emulator #(
  parameter int FRAME_DIV = 4,
  parameter int BC_MAX    = 3563,
  parameter int MAX_DLY   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  tds_pad_frame_emulator_if.slave       bus,
  output logic [1:0]                    state_dbg
);

  localparam int DW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_q;
  logic [11:0]    bcid_q;
  logic [31:0]    frame_count_q;
  logic [113:0]   stage_q [0:MAX_DLY];
  logic [113:0]   stage_d [0:MAX_DLY];
  logic [115:0]   pad_q   [4];
  logic [2:0]     sel     [4];
  logic [2:0]     eff_sel [4];
  logic [3:0]     valid_q;
  logic           bc0_q;
  logic [101:0]   payload;
  logic           strobe;

`ifdef TDS_EMU_PRBS_EN
  logic [30:0]    lfsr_q;
  logic [132:0]   prbs_out;

  // One frame of PRBS-31 (x^31 + x^28 + 1): {next LFSR state, 102 payload bits}.
  function automatic logic [132:0] prbs_adv(input logic [30:0] s_in);
    logic [30:0]  s;
    logic [101:0] bits;
    logic         fb;
    s    = s_in;
    bits = '0;
    for (int i = 0; i < 102; i++) begin
      fb      = s[30] ^ s[27];
      bits[i] = fb;
      s       = {s[29:0], fb};
    end
    return {s, bits};
  endfunction

  assign prbs_out = prbs_adv(lfsr_q);
  assign payload  = prbs_out[101:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                lfsr_q <= 31'h7FFF_FFFF;
    else if (strobe)           lfsr_q <= prbs_out[132:102];
  end
`else
  assign payload = {70'd0, frame_count_q};
`endif

  assign sel[0] = bus.delay_sel_0;
  assign sel[1] = bus.delay_sel_1;
  assign sel[2] = bus.delay_sel_2;
  assign sel[3] = bus.delay_sel_3;

  assign strobe = (state_q == S_RUN) && (div_q == DW'(FRAME_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.enable) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (!bus.enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Delay line as it will look after this strobe; outputs pick from it so a link
  // with delay 0 carries the frame being generated now.
  always_comb begin
    stage_d[0] = {bcid_q, payload};
    for (int i = 1; i <= MAX_DLY; i++) stage_d[i] = stage_q[i-1];
    for (int k = 0; k < 4; k++)
      eff_sel[k] = (sel[k] > 3'(MAX_DLY)) ? 3'(MAX_DLY) : sel[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      bcid_q        <= '0;
      frame_count_q <= '0;
      valid_q       <= '0;
      bc0_q         <= 1'b0;
      for (int i = 0; i <= MAX_DLY; i++) stage_q[i] <= '0;
      for (int k = 0; k < 4; k++) pad_q[k] <= '0;
    end else begin
      valid_q <= '0;
      bc0_q   <= 1'b0;
      if (state_q == S_LOAD) begin
        bcid_q        <= (bus.bcid_preset > 12'(BC_MAX)) ? 12'd0 : bus.bcid_preset;
        div_q         <= '0;
        frame_count_q <= '0;
        for (int i = 0; i <= MAX_DLY; i++) stage_q[i] <= '0;
      end else if (state_q == S_RUN) begin
        div_q <= strobe ? '0 : div_q + 1'b1;
        if (strobe) begin
          stage_q       <= stage_d;
          bcid_q        <= (bcid_q == 12'(BC_MAX)) ? 12'd0 : bcid_q + 12'd1;
          frame_count_q <= frame_count_q + 32'd1;
          valid_q       <= 4'hF;
          bc0_q         <= (bcid_q == 12'd0);
          for (int k = 0; k < 4; k++)
            pad_q[k] <= {stage_d[eff_sel[k]][113:102], 2'(k), stage_d[eff_sel[k]][101:0]};
        end
      end
    end
  end

  assign bus.pad_data_0       = pad_q[0];
  assign bus.pad_data_1       = pad_q[1];
  assign bus.pad_data_2       = pad_q[2];
  assign bus.pad_data_3       = pad_q[3];
  assign bus.pad_data_valid_0 = valid_q[0];
  assign bus.pad_data_valid_1 = valid_q[1];
  assign bus.pad_data_valid_2 = valid_q[2];
  assign bus.pad_data_valid_3 = valid_q[3];
  assign bus.bc0              = bc0_q;
  assign bus.frame_count      = frame_count_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_tds_pad_frame_emulator.sv
// Directed bench for tds_pad_frame_emulator (default build, frame_count payload).
module tb_tds_pad_frame_emulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  int         n_pass = 0;
  int         n_total = 0;
  int         gap;
  int         cnt;

  tds_pad_frame_emulator_if bus ();

  tds_pad_frame_emulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [115:0] expf(input int bcid, input int k, input int pl);
    logic [11:0] b;
    logic [1:0]  l;
    b = 12'(bcid);
    l = 2'(k);
    return {b, l, 102'(pl)};
  endfunction

  // Ticks until the frame strobe, bounded; returns the number of cycles waited.
  task automatic wait_frame(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.pad_data_valid_0 && n < 40);
    check({tag, "_valid_all"}, {bus.pad_data_valid_3, bus.pad_data_valid_2,
                                 bus.pad_data_valid_1, bus.pad_data_valid_0}, 4'hF);
  endtask

  task automatic set_sel(input logic [2:0] s0, s1, s2, s3);
    bus.delay_sel_0 = s0;
    bus.delay_sel_1 = s1;
    bus.delay_sel_2 = s2;
    bus.delay_sel_3 = s3;
  endtask

  task automatic start(input logic [11:0] preset);
    bus.enable      = 1'b0;
    tick();
    bus.bcid_preset = preset;
    bus.enable      = 1'b1;
  endtask

  initial begin
    bus.enable      = 1'b0;
    bus.bcid_preset = 12'd0;
    set_sel(3'd0, 3'd0, 3'd0, 3'd0);

    // Reset state
    repeat (3) tick();
    check("rst_pad0", bus.pad_data_0, 116'd0);
    check("rst_fc", bus.frame_count, 32'd0);
    check("rst_valid", bus.pad_data_valid_0, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    rst_n = 1'b1;
    tick();

    // Basic run from preset 100
    bus.bcid_preset = 12'd100;
    bus.enable      = 1'b1;
    wait_frame("f100", gap);
    check("first_latency", gap, 6);
    check("f100_l0", bus.pad_data_0, expf(100, 0, 0));
    check("f100_l1", bus.pad_data_1, expf(100, 1, 0));
    check("f100_l2", bus.pad_data_2, expf(100, 2, 0));
    check("f100_l3", bus.pad_data_3, expf(100, 3, 0));
    check("f100_fc", bus.frame_count, 32'd1);
    check("f100_bc0", bus.bc0, 1'b0);
    tick();
    check("valid_one_cycle", bus.pad_data_valid_0, 1'b0);
    check("pad_hold", bus.pad_data_0, expf(100, 0, 0));
    wait_frame("f101", gap);
    check("spacing_101", gap, 3);
    check("f101_l3", bus.pad_data_3, expf(101, 3, 1));
    wait_frame("f102", gap);
    check("spacing_102", gap, 4);
    check("f102_l0", bus.pad_data_0, expf(102, 0, 2));

    // Idle holds outputs
    bus.enable = 1'b0;
    repeat (6) tick();
    check("idle_valid", bus.pad_data_valid_0, 1'b0);
    check("idle_fc_hold", bus.frame_count, 32'd3);
    check("idle_pad_hold", bus.pad_data_0, expf(102, 0, 2));
    check("idle_state", state_dbg, 2'd0);

    // BCID wrap 3562, 3563, 0, 1 with bc0 on the BCID 0 frame only
    start(12'd3562);
    wait_frame("w0", gap);
    check("w0_l1", bus.pad_data_1, expf(3562, 1, 0));
    check("w0_bc0", bus.bc0, 1'b0);
    wait_frame("w1", gap);
    check("w1_l1", bus.pad_data_1, expf(3563, 1, 1));
    check("w1_bc0", bus.bc0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.bc0) cnt++;
    end
    check("w2_l1", bus.pad_data_1, expf(0, 1, 2));
    check("w2_bc0", bus.bc0, 1'b1);
    check("w2_bc0_once", cnt, 1);
    wait_frame("w3", gap);
    check("w3_l1", bus.pad_data_1, expf(1, 1, 3));
    check("w3_bc0", bus.bc0, 1'b0);

    // Per-link delays 0,1,2,3 from preset 0, read at the sixth frame
    set_sel(3'd0, 3'd1, 3'd2, 3'd3);
    start(12'd0);
    for (int i = 0; i < 6; i++) wait_frame("dly", gap);
    check("dly_l0", bus.pad_data_0, expf(5, 0, 5));
    check("dly_l1", bus.pad_data_1, expf(4, 1, 4));
    check("dly_l2", bus.pad_data_2, expf(3, 2, 3));
    check("dly_l3", bus.pad_data_3, expf(2, 3, 2));
    check("dly_fc", bus.frame_count, 32'd6);

    // delay_sel 7 clamps to the deepest stage; unfilled stages read zero + link index
    set_sel(3'd0, 3'd0, 3'd7, 3'd0);
    start(12'd10);
    for (int i = 0; i < 4; i++) begin
      wait_frame("clamp", gap);
      check("clamp_empty_l2", bus.pad_data_2, expf(0, 2, 0));
      check("clamp_l0", bus.pad_data_0, expf(10 + i, 0, i));
    end
    wait_frame("clamp4", gap);
    check("clamp_l2_f4", bus.pad_data_2, expf(10, 2, 0));
    wait_frame("clamp5", gap);
    check("clamp_l2_f5", bus.pad_data_2, expf(11, 2, 1));

    // enable dropped during the strobe cycle still emits that frame
    set_sel(3'd0, 3'd0, 3'd0, 3'd0);
    start(12'd200);
    wait_frame("drop0", gap);
    check("drop0_l0", bus.pad_data_0, expf(200, 0, 0));
    repeat (3) tick();
    bus.enable = 1'b0;
    tick();
    check("drop_valid", bus.pad_data_valid_0, 1'b1);
    check("drop_l0", bus.pad_data_0, expf(201, 0, 1));
    check("drop_fc", bus.frame_count, 32'd2);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.pad_data_valid_0) cnt++;
    end
    check("drop_no_more", cnt, 0);
    bus.bcid_preset = 12'd50;
    bus.enable      = 1'b1;
    wait_frame("reen", gap);
    check("reen_latency", gap, 6);
    check("reen_l0", bus.pad_data_0, expf(50, 0, 0));
    check("reen_fc", bus.frame_count, 32'd1);

    // Out-of-range preset loads BCID 0
    start(12'd4095);
    wait_frame("oor", gap);
    check("oor_l3", bus.pad_data_3, expf(0, 3, 0));
    check("oor_bc0", bus.bc0, 1'b1);

    // Asynchronous reset mid-RUN
    wait_frame("pre_rst", gap);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_pad1", bus.pad_data_1, 116'd0);
    check("arst_fc", bus.frame_count, 32'd0);
    check("arst_state", state_dbg, 2'd0);
    tick();
    rst_n = 1'b1;
    wait_frame("post_rst", gap);
    check("post_rst_latency", gap, 6);
    check("post_rst_l2", bus.pad_data_2, expf(0, 2, 0));
    check("post_rst_fc", bus.frame_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
